// File: rtl/dot_product_engine.sv
// Frame-based dot-product stage: pops one packed word from each input FIFO,
// multiplies element-wise per lane, sums and pushes a truncated result with overflow flag.

module dot_product_lane #(
  parameter int ELEM_WIDTH = 8
) (
  input  logic [ELEM_WIDTH-1:0]   a,
  input  logic [ELEM_WIDTH-1:0]   b,
  output logic [2*ELEM_WIDTH-1:0] p
);
  assign p = {{ELEM_WIDTH{1'b0}}, a} * {{ELEM_WIDTH{1'b0}}, b};
endmodule

module dot_product_engine #(
  parameter int DATA_WIDTH           = 32,
  parameter int VECTOR_WIDTH         = 4,
  parameter int VECTOR_ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH           = 5,
  parameter int RESULT_WIDTH         = 2*VECTOR_ELEMENT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     num_vectors,
  input  logic                    fifo1_empty,
  input  logic                    fifo2_empty,
  input  logic [DATA_WIDTH-1:0]   fifo1_data,
  input  logic [DATA_WIDTH-1:0]   fifo2_data,
  output logic                    fifo1_rd_en,
  output logic                    fifo2_rd_en,
  input  logic                    fifo3_full,
  output logic                    fifo3_wr_en,
  output logic [RESULT_WIDTH-1:0] fifo3_data,
  output logic                    result_ovf,
  output logic                    ovf_seen,
  output logic                    busy,
  output logic                    done
);
  localparam int PW      = 2*VECTOR_ELEMENT_WIDTH;
  localparam int SUM_NAT = PW + $clog2(VECTOR_WIDTH+1);
  // Sum kept at least one bit wider than the result so overflow is always detectable.
  localparam int SW      = (SUM_NAT > RESULT_WIDTH) ? SUM_NAT : RESULT_WIDTH+1;

  typedef enum logic [2:0] {IDLE, POP, WAIT, SUM, PUSH, DONE} state_t;

  state_t                                               state;
  logic [ADDR_WIDTH:0]                                  remaining;
  logic [VECTOR_WIDTH-1:0][VECTOR_ELEMENT_WIDTH-1:0]    a_vec, b_vec;
  logic [VECTOR_WIDTH-1:0][PW-1:0]                      prod, prod_q;
  logic [SW-1:0]                                        sum;
  logic                                                 pop_ok;

  assign a_vec = fifo1_data;
  assign b_vec = fifo2_data;

  dot_product_lane #(.ELEM_WIDTH(VECTOR_ELEMENT_WIDTH)) u_lane [VECTOR_WIDTH-1:0] (
    .a(a_vec),
    .b(b_vec),
    .p(prod)
  );

  always_comb begin
    sum = '0;
    for (int i = 0; i < VECTOR_WIDTH; i++) sum = sum + SW'(prod_q[i]);
  end

  // Both FIFOs are popped together or not at all.
  assign pop_ok      = (state == POP) && !fifo1_empty && !fifo2_empty;
  assign fifo1_rd_en = pop_ok;
  assign fifo2_rd_en = pop_ok;
  assign fifo3_wr_en = (state == PUSH) && !fifo3_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      prod_q     <= '0;
      fifo3_data <= '0;
      result_ovf <= 1'b0;
      ovf_seen   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (num_vectors != '0) begin
            remaining <= num_vectors;
            ovf_seen  <= 1'b0;
            state     <= POP;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        POP:  if (pop_ok) state <= WAIT;
        WAIT: begin
          prod_q <= prod;
          state  <= SUM;
        end
        SUM: begin
          fifo3_data <= sum[RESULT_WIDTH-1:0];
          result_ovf <= |sum[SW-1:RESULT_WIDTH];
          state      <= PUSH;
        end
        PUSH: if (fifo3_wr_en) begin
          remaining <= remaining - (ADDR_WIDTH+1)'(1);
          ovf_seen  <= ovf_seen | result_ovf;
          if (remaining == (ADDR_WIDTH+1)'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= POP;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Handshaked dot-product stage between the two input vector FIFOs (fed by the memory readers) and the result FIFO (drained by the memory writer). On `start` it processes a frame of `num_vectors` word pairs. For each pair it pops one packed word from each input FIFO, computes the unsigned dot product of the packed elements and pushes one result into the output FIFO. It stalls on empty inputs or a full output and never drops or duplicates data.

## Interface
Parameters:
- DATA_WIDTH, 32: width of a packed input word; must equal VECTOR_WIDTH*VECTOR_ELEMENT_WIDTH.
- VECTOR_WIDTH, 4: elements per word.
- VECTOR_ELEMENT_WIDTH, 8: unsigned element width.
- ADDR_WIDTH, 5: frame length counter base width.
- RESULT_WIDTH, 2*VECTOR_ELEMENT_WIDTH: width of a pushed result.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- num_vectors  in  ADDR_WIDTH+1  word pairs in the frame; latched on accepted start.
- fifo1_empty, fifo2_empty  in  1  input FIFO empty flags.
- fifo1_data, fifo2_data  in  DATA_WIDTH  input FIFO read data; valid the cycle after rd_en.
- fifo1_rd_en, fifo2_rd_en  out  1  pop strobes; always asserted together.
- fifo3_full  in  1  output FIFO full flag.
- fifo3_wr_en  out  1  push strobe.
- fifo3_data  out  RESULT_WIDTH  result, registered.
- result_ovf  out  1  result truncated; valid with fifo3_wr_en.
- ovf_seen  out  1  sticky OR of result_ovf over the frame; cleared on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, POP, WAIT, SUM, PUSH, DONE.
- IDLE:
  - start=1 with num_vectors≠0 latches remaining=num_vectors, clears ovf_seen, goes to POP.
  - start=1 with num_vectors=0 goes to DONE.
- POP: fifoN_rd_en = !fifo1_empty && !fifo2_empty, driven combinationally. When asserted, go to WAIT; otherwise hold in POP. Never pop only one FIFO.
- WAIT: fifo data is valid. Register VECTOR_WIDTH products p[i] = a[i]*b[i], each 2*VECTOR_ELEMENT_WIDTH bits, unsigned. Element i is bits [i*VECTOR_ELEMENT_WIDTH +: VECTOR_ELEMENT_WIDTH]. Go to SUM.
- SUM: compute the full-width sum S of p[i]. Register fifo3_data = S mod 2^RESULT_WIDTH. Register result_ovf = (S ≥ 2^RESULT_WIDTH). Go to PUSH.
- PUSH: fifo3_wr_en = !fifo3_full, driven combinationally. When asserted:
  - decrement remaining;
  - OR result_ovf into ovf_seen;
  - go to DONE if remaining was 1, else go to POP.
  - If full, hold PUSH with fifo3_data stable.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- num_vectors changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, all outputs 0 (rd_en, wr_en, fifo3_data, result_ovf, ovf_seen, busy, done), remaining=0.
- rst has priority over all other inputs. Asserting it mid-frame abandons the frame:
  - no further pops or pushes;
  - no done pulse;
  - start is accepted the first cycle after rst deasserts.
- With no stalls, for start accepted at edge T:
  - rd_en is high in cycle T+1;
  - wr_en is high in cycle T+4;
  - each further pair adds 4 cycles;
  - done is high in cycle T+4·N+1 for N pairs.
- num_vectors=0: done is high in cycle T+1; no pops or pushes.
- Each stall cycle (inputs empty in POP, output full in PUSH) delays all later events by exactly one cycle.
- Exactly N pops per FIFO and N pushes per frame.
- Maximum frame length is 2^(ADDR_WIDTH+1)-1.

## Test plan
- Basic: N=1, a=0x04030201, b=0x01010101 → one push, fifo3_data=0x000A, result_ovf=0, done 5 cycles after start.
- Overflow: a=b=0xFFFFFFFF → S=260100, fifo3_data=0xF804, result_ovf=1, ovf_seen=1 after push. A following frame with start clears ovf_seen.
- Empty stall: N=3, fifo2_empty held high 6 cycles during the 2nd POP → rd_en low throughout the stall, never asymmetric. Results arrive in order, exactly 3 pushes.
- Full stall: fifo3_full high 5 cycles in PUSH → wr_en low, fifo3_data stable, single push when full drops, total frame 5 cycles longer.
- Zero length and ignored start: N=0 → done in the cycle after start, no strobes. Pulsing start while busy → no effect on count or state.
- Reset mid-frame: rst during SUM of pair 2 of N=4 → all outputs 0 next cycle, no done. A new N=1 frame then completes correctly.
